// File: rtl/register_file_pkg.sv
// Shared definitions for the configuration/operand register file.
// Address map of the dedicated registers, their reset values and the
// field layout of the UART configuration register (reg2).
package register_file_pkg;

  // Dedicated register addresses
  localparam int REG_OPA       = 0;
  localparam int REG_OPB       = 1;
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  // Reset values: parity enabled, even parity, prescale 32; divide ratio 32
  localparam logic [7:0] REG2_RST_VAL = 8'h81;
  localparam logic [7:0] REG3_RST_VAL = 8'h20;

  // UART configuration field positions inside reg2
  localparam int PAR_EN_BIT   = 0;
  localparam int PAR_TYP_BIT  = 1;
  localparam int PRESCALE_LSB = 2;
  localparam int PRESCALE_MSB = 7;

  // Extract the prescale field from a UART configuration byte
  function automatic logic [PRESCALE_MSB-PRESCALE_LSB:0] uart_prescale(input logic [7:0] cfg);
    return cfg[PRESCALE_MSB:PRESCALE_LSB];
  endfunction

endpackage

// File: rtl/register_file_if.sv
// Controller <-> register file bus.
//   WR_EN      write strobe (one cycle per write)
//   RD_EN      read strobe (may be held)
//   ADDR       register address
//   WR_D       write data
//   RD_D       registered read data
//   RD_D_VALID high the cycle after an accepted read
// master = system controller, slave = register file.
interface register_file_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  WR_EN;
  logic                  RD_EN;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] WR_D;
  logic [DATA_WIDTH-1:0] RD_D;
  logic                  RD_D_VALID;

  modport master (
    output WR_EN, RD_EN, ADDR, WR_D,
    input  RD_D, RD_D_VALID
  );

  modport slave (
    input  WR_EN, RD_EN, ADDR, WR_D,
    output RD_D, RD_D_VALID
  );
endinterface

// File: rtl/register_file.sv
// 16x8 configuration and operand register file.
// Single-cycle writes and reads from the system controller, read data
// returned one cycle later with a valid flag. Registers 0..3 are also
// exposed continuously to the datapath.
// Ports:
//   CLK   system clock, rising edge
//   RST   asynchronous active-low reset
//   bus   controller bus (slave side), see register_file_if
//   REG0  ALU operand A
//   REG1  ALU operand B
//   REG2  UART config: bit0 PAR_EN, bit1 PAR_TYP, bits[7:2] PRESCALE
//   REG3  clock-divider ratio
module register_file
  import register_file_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] REG2_RST   = REG2_RST_VAL,
  parameter logic [DATA_WIDTH-1:0] REG3_RST   = REG3_RST_VAL
) (
  input  logic                  CLK,
  input  logic                  RST,
  register_file_if.slave        bus,
  output logic [DATA_WIDTH-1:0] REG0,
  output logic [DATA_WIDTH-1:0] REG1,
  output logic [DATA_WIDTH-1:0] REG2,
  output logic [DATA_WIDTH-1:0] REG3
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_d_p1;
  logic                  vld_p1;
  logic                  in_range;
  logic                  wr_acc;
  logic                  rd_acc;

  // Only reachable when DEPTH is not a power of two
  assign in_range = (32'(bus.ADDR) < DEPTH);
  // Both strobes together is an illegal request: neither is honoured
  assign wr_acc   = bus.WR_EN && !bus.RD_EN;
  assign rd_acc   = bus.RD_EN && !bus.WR_EN;

  // Stage p0 -> p1: storage update and registered read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      mem[REG_UART_CFG]  <= REG2_RST;
      mem[REG_DIV_RATIO] <= REG3_RST;
      rd_d_p1            <= '0;
      vld_p1             <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (wr_acc) begin
        if (in_range) begin
          mem[bus.ADDR] <= bus.WR_D;
        end
      end else if (rd_acc) begin
        vld_p1  <= 1'b1;
        rd_d_p1 <= in_range ? mem[bus.ADDR] : '0;
      end
    end
  end

  assign bus.RD_D       = rd_d_p1;
  assign bus.RD_D_VALID = vld_p1;

  assign REG0 = mem[REG_OPA];
  assign REG1 = mem[REG_OPB];
  assign REG2 = mem[REG_UART_CFG];
  assign REG3 = mem[REG_DIV_RATIO];

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios followed by randomized
// traffic, all outputs compared against a behavioural model each cycle.
module tb_register_file;
  import register_file_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] REG0, REG1, REG2, REG3;

  register_file_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  register_file dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus.slave),
    .REG0 (REG0),
    .REG1 (REG1),
    .REG2 (REG2),
    .REG3 (REG3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model
  logic [7:0] ref_mem [16];
  logic [7:0] ref_rd;
  logic       ref_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    ref_mem[2] = 8'h81;
    ref_mem[3] = 8'h20;
    ref_rd  = 8'h00;
    ref_vld = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".vld"},  {31'd0, bus.RD_D_VALID}, {31'd0, ref_vld});
    check({tag, ".rd"},   {24'd0, bus.RD_D}, {24'd0, ref_rd});
    check({tag, ".reg0"}, {24'd0, REG0}, {24'd0, ref_mem[0]});
    check({tag, ".reg1"}, {24'd0, REG1}, {24'd0, ref_mem[1]});
    check({tag, ".reg2"}, {24'd0, REG2}, {24'd0, ref_mem[2]});
    check({tag, ".reg3"}, {24'd0, REG3}, {24'd0, ref_mem[3]});
  endtask

  // One bus cycle: drive on the falling edge, model the rising edge,
  // sample 1 ns after it.
  task automatic cycle(input bit w, input bit r, input logic [3:0] a, input logic [7:0] d,
                       input string tag);
    @(negedge CLK);
    bus.WR_EN = w;
    bus.RD_EN = r;
    bus.ADDR  = a;
    bus.WR_D  = d;
    @(posedge CLK);
    if (w && !r) begin
      ref_mem[a] = d;
      ref_vld    = 1'b0;
    end else if (r && !w) begin
      ref_rd  = ref_mem[a];
      ref_vld = 1'b1;
    end else begin
      ref_vld = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    RST        = 1'b0;
    bus.WR_EN  = 1'b0;
    bus.RD_EN  = 1'b0;
    bus.ADDR   = '0;
    bus.WR_D   = '0;
    model_reset();

    // Reset state
    #12;
    check("rst.reg0", {24'd0, REG0}, 32'h00);
    check("rst.reg1", {24'd0, REG1}, 32'h00);
    check("rst.reg2", {24'd0, REG2}, 32'h81);
    check("rst.reg3", {24'd0, REG3}, 32'h20);
    check("rst.rd",   {24'd0, bus.RD_D}, 32'h00);
    check("rst.vld",  {31'd0, bus.RD_D_VALID}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    cycle(0, 1, 4'd5, 8'h00, "rd5");
    check("rd5.val", {24'd0, bus.RD_D}, 32'h00);

    // Consecutive writes to operand registers
    cycle(1, 0, 4'd0, 8'h3C, "wr0");
    check("wr0.reg0", {24'd0, REG0}, 32'h3C);
    cycle(1, 0, 4'd1, 8'h05, "wr1");
    check("wr1.reg1", {24'd0, REG1}, 32'h05);

    // Held read of addr 9, then idle
    cycle(1, 0, 4'd9, 8'hA5, "wr9");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 4'd9, 8'h00, "hold9");
      check("hold9.vld", {31'd0, bus.RD_D_VALID}, 32'h1);
      check("hold9.val", {24'd0, bus.RD_D}, 32'hA5);
    end
    cycle(0, 0, 4'd9, 8'h00, "idle");
    check("idle.vld", {31'd0, bus.RD_D_VALID}, 32'h0);
    check("idle.hold", {24'd0, bus.RD_D}, 32'hA5);

    // Both strobes: nothing happens
    cycle(1, 1, 4'd4, 8'hFF, "both");
    check("both.vld", {31'd0, bus.RD_D_VALID}, 32'h0);
    cycle(0, 1, 4'd4, 8'h00, "rd4");
    check("rd4.val", {24'd0, bus.RD_D}, 32'h00);

    // Reprogram UART config and read back next cycle
    cycle(1, 0, 4'd2, 8'h42, "wr2");
    cycle(0, 1, 4'd2, 8'h00, "rd2");
    check("rd2.val", {24'd0, bus.RD_D}, 32'h42);
    check("rd2.reg2", {24'd0, REG2}, 32'h42);
    check("rd2.par_en", {31'd0, REG2[PAR_EN_BIT]}, 32'h0);
    check("rd2.par_typ", {31'd0, REG2[PAR_TYP_BIT]}, 32'h1);
    check("rd2.prescale", {26'd0, uart_prescale(REG2)}, 32'd16);

    // Asynchronous reset during a held read of addr 9
    cycle(0, 1, 4'd9, 8'h00, "pre_rst");
    check("pre_rst.val", {24'd0, bus.RD_D}, 32'hA5);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check("async.vld",  {31'd0, bus.RD_D_VALID}, 32'h0);
    check("async.reg2", {24'd0, REG2}, 32'h81);
    check("async.rd",   {24'd0, bus.RD_D}, 32'h00);
    @(negedge CLK);
    bus.RD_EN = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    cycle(0, 1, 4'd9, 8'h00, "post_rst");
    check("post_rst.val", {24'd0, bus.RD_D}, 32'h00);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int  sel;
      bit  w, r;
      sel = int'($urandom_range(0, 19));
      w = (sel < 8) || (sel == 19);
      r = (sel >= 8 && sel < 16) || (sel == 19);
      cycle(w, r, 4'($urandom_range(0, 15)), 8'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
